hyper_cfg_sequencer: RTL and testbench
======================================

HYPER_CFG_SEQUENCER -- requirements
Module: hyper_cfg_sequencer

Interface
REQ-001 SHALL have parameter NumCfg, default 4, number of boot-time config writes (legal range 1..16).
REQ-002 SHALL have parameter StartupCycles, default 60000, PHY settle cycles before the first write (legal range >=1).
REQ-003 SHALL have parameter AddrWidth, default 48, register address width.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port cfg_addr_i, input, NumCfg x AddrWidth, config write addresses, static.
REQ-007 SHALL have port cfg_data_i, input, NumCfg x 32, config write data, static.
REQ-008 SHALL have port cfg_en_i, input, NumCfg, per-entry enable; a 0 entry is skipped.
REQ-009 SHALL have port reinit_i, input, 1, pulse requesting the config list be replayed.
REQ-010 SHALL have ports ext_valid_i/ext_write_i/ext_addr_i/ext_wdata_i/ext_wstrb_i, inputs, 1/1/AddrWidth/32/4, SoC register request.
REQ-011 SHALL have ports ext_ready_o/ext_rdata_o/ext_error_o, outputs, 1/32/1, SoC register response.
REQ-012 SHALL have ports reg_valid_o/reg_write_o/reg_addr_o/reg_wdata_o/reg_wstrb_o, outputs, 1/1/AddrWidth/32/4, request to the HyperBus config port.
REQ-013 SHALL have ports reg_ready_i/reg_rdata_i/reg_error_i, inputs, 1/32/1, HyperBus config response.
REQ-014 SHALL have port init_done_o, output, 1, high once the config list has completed.
REQ-015 SHALL have port init_error_o, output, 1, sticky flag: some config write returned an error.
REQ-016 SHALL have port mem_gate_o, output, 1, high when DRAM AXI traffic must be held off.

Function
REQ-017 The register handshake SHALL be: the request completes in any cycle where valid and ready are both high; the master holds valid and payload stable until then; ready may be combinational.
REQ-018 The FSM SHALL have four states: STARTUP, SEEK, ISSUE, DONE.
REQ-019 STARTUP: the counter SHALL go from 0 to StartupCycles-1, then move to SEEK with idx=0.
REQ-020 SEEK: if cfg_en_i[idx]=1, go to ISSUE; else increment idx; when idx=NumCfg-1 and it is skipped, go to DONE. Each skip SHALL cost exactly one cycle.
REQ-021 ISSUE: drive reg_valid_o=1, reg_write_o=1, reg_wstrb_o=4'hF, reg_addr_o=cfg_addr_i[idx], reg_wdata_o=cfg_data_i[idx].
REQ-022 On handshake in ISSUE: if reg_error_i=1, set init_error_o; if idx=NumCfg-1, go to DONE; else increment idx and go to SEEK.
REQ-023 In ISSUE there SHALL be no timeout; the FSM waits indefinitely for reg_ready_i.
REQ-024 DONE: ext_* SHALL pass through combinationally to reg_* and back (reg_valid_o=ext_valid_i, ext_ready_o=reg_ready_i, ext_rdata_o=reg_rdata_i, ext_error_o=reg_error_i).
REQ-025 Outside DONE, ext_ready_o=0 and ext_error_o=0, ext_rdata_o=0, and SoC requests SHALL be stalled, never dropped or errored.
REQ-026 init_done_o=1 and mem_gate_o=0 SHALL hold only in DONE; otherwise init_done_o=0 and mem_gate_o=1.
REQ-027 reinit_i pulse in DONE SHALL set reinit_pend; reinit_i outside DONE SHALL be ignored.
REQ-028 With reinit_pend set, the FSM SHALL stay in DONE, keep the passthrough, and in the first cycle with ext_valid_i=0 clear reinit_pend, clear init_error_o, set idx=0 and go to SEEK; STARTUP is not re-entered.
REQ-029 The first config request SHALL be valid exactly StartupCycles cycles after the first cycle with rst_i low, if cfg_en_i[0]=1.
REQ-030 idx SHALL be $clog2(NumCfg) bits wide (minimum 1) and SHALL never exceed NumCfg-1.

Reset
REQ-031 While rst_i=1 at a clock edge: state=STARTUP, counter=0, idx=0, reinit_pend=0, init_error_o=0.
REQ-032 Outputs during and after reset: reg_valid_o=0, ext_ready_o=0, init_done_o=0, mem_gate_o=1, all data outputs 0.
REQ-033 Reset asserted mid-ISSUE SHALL abandon the write without completing it, and the sequence SHALL restart from STARTUP.

Verification (StartupCycles=8, NumCfg=3)
REQ-034 Scenario: cfg_en=3'b111, ready=1 -> reg_valid_o first high at cycle 8 after reset release; 3 writes on cycles 8, 10, 12; init_done_o rises at cycle 13.
REQ-035 Scenario: cfg_en=3'b010 -> exactly one write, to cfg_addr_i[1]; cfg_en=3'b000 -> zero writes and DONE reached with no reg_valid_o.
REQ-036 Scenario: reg_error_i=1 on write 2, ready delayed 5 cycles -> init_error_o=1 sticky, sequence completes, valid and payload stable throughout the stall.
REQ-037 Scenario: ext_valid_i held from cycle 2 -> ext_ready_o=0 until DONE, then the request completes via passthrough with rdata returned.
REQ-038 Scenario: reinit_i while ext_valid_i=1 and ready low -> the ext transaction completes first, then replay from idx 0 with init_done_o=0 and mem_gate_o=1 during the replay.
REQ-039 Scenario: rst_i pulsed mid-ISSUE -> outputs return to reset values next cycle and STARTUP restarts with full count.

Source files
------------

// File: rtl/hyper_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hyper_cfg_sequencer
//  Description : Boot-time HyperBus register configurator. Waits for the PHY
//                to settle, replays a static list of register writes onto the
//                HyperBus config port, then hands the port to the SoC as a
//                combinational passthrough. DRAM traffic is gated until the
//                list has completed. A reinit request replays the list once
//                the SoC port is idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module hyper_cfg_sequencer #(
    parameter int NumCfg        = 4,
    parameter int StartupCycles = 60000,
    parameter int AddrWidth     = 48
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    // static configuration list
    input  logic [NumCfg-1:0][AddrWidth-1:0]  cfg_addr_i,
    input  logic [NumCfg-1:0][31:0]           cfg_data_i,
    input  logic [NumCfg-1:0]                 cfg_en_i,
    input  logic                              reinit_i,
    // SoC register request / response
    input  logic                              ext_valid_i,
    input  logic                              ext_write_i,
    input  logic [AddrWidth-1:0]              ext_addr_i,
    input  logic [31:0]                       ext_wdata_i,
    input  logic [3:0]                        ext_wstrb_i,
    output logic                              ext_ready_o,
    output logic [31:0]                       ext_rdata_o,
    output logic                              ext_error_o,
    // HyperBus config port request / response
    output logic                              reg_valid_o,
    output logic                              reg_write_o,
    output logic [AddrWidth-1:0]              reg_addr_o,
    output logic [31:0]                       reg_wdata_o,
    output logic [3:0]                        reg_wstrb_o,
    input  logic                              reg_ready_i,
    input  logic [31:0]                       reg_rdata_i,
    input  logic                              reg_error_i,
    // status
    output logic                              init_done_o,
    output logic                              init_error_o,
    output logic                              mem_gate_o
);

    localparam int c_IDX_W = (NumCfg > 1) ? $clog2(NumCfg) : 1;
    localparam int c_CNT_W = (StartupCycles > 1) ? $clog2(StartupCycles) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NumCfg - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(StartupCycles - 1);

    localparam logic [1:0] c_ST_STARTUP = 2'd0;
    localparam logic [1:0] c_ST_SEEK    = 2'd1;
    localparam logic [1:0] c_ST_ISSUE   = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    logic [1:0]           r_state;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_reinit_pend;
    logic                 r_init_error;
    logic                 r_req_valid;
    logic [AddrWidth-1:0] r_req_addr;
    logic [31:0]          r_req_data;

    logic [c_IDX_W-1:0]   w_seek_idx;
    logic                 w_seek_en;
    logic                 w_seek_last;
    logic [1:0]           w_seek_next_state;
    logic [c_IDX_W-1:0]   w_seek_next_idx;
    logic                 w_in_done;

    // Entry-selection step shared by SEEK and by the final settle cycle. The
    // last STARTUP cycle evaluates entry 0 itself, so an enabled first entry
    // is presented exactly StartupCycles cycles after reset release.
    always_comb begin
        w_seek_idx        = (r_state == c_ST_STARTUP) ? '0 : r_idx;
        w_seek_en         = cfg_en_i[w_seek_idx];
        w_seek_last       = (w_seek_idx == c_IDX_LAST);
        w_seek_next_state = c_ST_SEEK;
        w_seek_next_idx   = w_seek_idx + c_IDX_W'(1);
        if (w_seek_en) begin
            w_seek_next_state = c_ST_ISSUE;
            w_seek_next_idx   = w_seek_idx;
        end else if (w_seek_last) begin
            w_seek_next_state = c_ST_DONE;
            w_seek_next_idx   = w_seek_idx;
        end
    end

    // Sequencer FSM: settle count, walk the list, issue writes, then serve
    // the SoC until a reinit is requested and the SoC port goes idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= c_ST_STARTUP;
            r_count       <= '0;
            r_idx         <= '0;
            r_reinit_pend <= 1'b0;
            r_init_error  <= 1'b0;
            r_req_valid   <= 1'b0;
            r_req_addr    <= '0;
            r_req_data    <= '0;
        end else begin
            case (r_state)
                c_ST_STARTUP, c_ST_SEEK: begin
                    if (r_state == c_ST_STARTUP && r_count != c_CNT_LAST) begin
                        r_count <= r_count + c_CNT_W'(1);
                    end else begin
                        r_state     <= w_seek_next_state;
                        r_idx       <= w_seek_next_idx;
                        r_req_valid <= w_seek_en;
                        r_req_addr  <= w_seek_en ? cfg_addr_i[w_seek_idx] : '0;
                        r_req_data  <= w_seek_en ? cfg_data_i[w_seek_idx] : '0;
                    end
                end
                c_ST_ISSUE: begin
                    // No timeout: the write is held until the port accepts it.
                    if (reg_ready_i) begin
                        r_req_valid <= 1'b0;
                        r_req_addr  <= '0;
                        r_req_data  <= '0;
                        if (reg_error_i) begin
                            r_init_error <= 1'b1;
                        end
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_idx   <= r_idx + c_IDX_W'(1);
                            r_state <= c_ST_SEEK;
                        end
                    end
                end
                c_ST_DONE: begin
                    // A pending replay waits for an idle SoC port so that no
                    // in-flight SoC request is cut off.
                    if (r_reinit_pend) begin
                        if (!ext_valid_i) begin
                            r_reinit_pend <= 1'b0;
                            r_init_error  <= 1'b0;
                            r_idx         <= '0;
                            r_state       <= c_ST_SEEK;
                        end
                    end else if (reinit_i) begin
                        r_reinit_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_STARTUP;
                end
            endcase
        end
    end

    assign w_in_done = (r_state == c_ST_DONE);

    // Port ownership: the sequencer drives the config port until DONE, after
    // which the SoC request/response path is wired straight through.
    assign reg_valid_o  = w_in_done ? ext_valid_i : r_req_valid;
    assign reg_write_o  = w_in_done ? ext_write_i : r_req_valid;
    assign reg_addr_o   = w_in_done ? ext_addr_i  : r_req_addr;
    assign reg_wdata_o  = w_in_done ? ext_wdata_i : r_req_data;
    assign reg_wstrb_o  = w_in_done ? ext_wstrb_i : {4{r_req_valid}};

    assign ext_ready_o  = w_in_done & reg_ready_i;
    assign ext_rdata_o  = w_in_done ? reg_rdata_i : 32'h0;
    assign ext_error_o  = w_in_done & reg_error_i;

    assign init_done_o  = w_in_done;
    assign mem_gate_o   = ~w_in_done;
    assign init_error_o = r_init_error;

endmodule
`default_nettype wire

// File: tb/tb_hyper_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hyper_cfg_sequencer
//  Description : Scoreboard bench for hyper_cfg_sequencer (StartupCycles=8,
//                NumCfg=3). Stimulus pushes expected config writes and SoC
//                responses into queues; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hyper_cfg_sequencer;

    localparam int N  = 3;
    localparam int SC = 8;
    localparam int AW = 48;

    logic                     clk;
    logic                     rst;
    logic [N-1:0][AW-1:0]     cfg_addr;
    logic [N-1:0][31:0]       cfg_data;
    logic [N-1:0]             cfg_en;
    logic                     reinit;
    logic                     ext_valid_i, ext_write_i;
    logic [AW-1:0]            ext_addr_i;
    logic [31:0]              ext_wdata_i;
    logic [3:0]               ext_wstrb_i;
    logic                     ext_ready_o, ext_error_o;
    logic [31:0]              ext_rdata_o;
    logic                     reg_valid_o, reg_write_o;
    logic [AW-1:0]            reg_addr_o;
    logic [31:0]              reg_wdata_o;
    logic [3:0]               reg_wstrb_o;
    logic                     reg_ready_i, reg_error_i;
    logic [31:0]              reg_rdata_i;
    logic                     init_done_o, init_error_o, mem_gate_o;

    hyper_cfg_sequencer #(.NumCfg(N), .StartupCycles(SC), .AddrWidth(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_en_i(cfg_en),
        .reinit_i(reinit),
        .ext_valid_i(ext_valid_i), .ext_write_i(ext_write_i), .ext_addr_i(ext_addr_i),
        .ext_wdata_i(ext_wdata_i), .ext_wstrb_i(ext_wstrb_i),
        .ext_ready_o(ext_ready_o), .ext_rdata_o(ext_rdata_o), .ext_error_o(ext_error_o),
        .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
        .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i),
        .init_done_o(init_done_o), .init_error_o(init_error_o), .mem_gate_o(mem_gate_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle index relative to the first cycle with reset low
    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct { logic [AW-1:0] addr; logic [31:0] data; int cyc; } wr_t;
    typedef struct { logic [31:0] rdata; logic err; } rsp_t;
    wr_t  exp_q[$];
    rsp_t ext_q[$];

    int checks = 0;
    int errors = 0;
    int cfg_hs = 0;
    int wait_cnt = 0;
    logic [AW-1:0] delay_addr, err_addr;
    int delay_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_cfg(input int i, input int c);
        wr_t e;
        e.addr = cfg_addr[i];
        e.data = cfg_data[i];
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_ext(input logic [31:0] rd, input logic er);
        rsp_t r;
        r.rdata = rd;
        r.err   = er;
        ext_q.push_back(r);
    endtask

    // Register slave: optional per-address stall, per-address error,
    // read data derived from the address.
    initial begin
        reg_ready_i = 1'b0;
        reg_error_i = 1'b0;
        reg_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            reg_ready_i = 1'b0;
            reg_error_i = 1'b0;
            reg_rdata_i = 32'h0;
            if (!rst && reg_valid_o) begin
                if (wait_cnt < ((reg_addr_o == delay_addr) ? delay_n : 0)) begin
                    wait_cnt++;
                end else begin
                    wait_cnt    = 0;
                    reg_ready_i = 1'b1;
                    reg_error_i = (reg_addr_o == err_addr);
                    reg_rdata_i = reg_addr_o[31:0] ^ 32'hA5A5_0000;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: config writes before DONE, passthrough transactions after.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (!init_done_o) begin
                    check("gated_ext_resp", 64'({ext_ready_o, ext_error_o, ext_rdata_o}), 64'(0));
                    check("mem_gate_busy", 64'(mem_gate_o), 64'(1));
                    if (reg_valid_o) begin
                        check("cfg_write_expected", 64'(exp_q.size() != 0), 64'(1));
                        if (exp_q.size() != 0) begin
                            check("cfg_addr", 64'(reg_addr_o), 64'(exp_q[0].addr));
                            check("cfg_data", 64'(reg_wdata_o), 64'(exp_q[0].data));
                            check("cfg_write_strb", 64'({reg_write_o, reg_wstrb_o}), 64'(5'h1F));
                            if (reg_ready_i) begin
                                if (exp_q[0].cyc >= 0)
                                    check("cfg_cycle", 64'(cyc), 64'(exp_q[0].cyc));
                                exp_q.delete(0);
                                cfg_hs++;
                            end
                        end
                    end
                end else if (ext_valid_i && ext_ready_o) begin
                    check("ext_rsp_expected", 64'(ext_q.size() != 0), 64'(1));
                    if (ext_q.size() != 0) begin
                        check("ext_rdata", 64'(ext_rdata_o), 64'(ext_q[0].rdata));
                        check("ext_error", 64'(ext_error_o), 64'(ext_q[0].err));
                        check("pass_addr", 64'(reg_addr_o), 64'(ext_addr_i));
                        check("pass_wr", 64'({reg_write_o, reg_wstrb_o, reg_wdata_o}),
                              64'({ext_write_i, ext_wstrb_i, ext_wdata_i}));
                        ext_q.delete(0);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid_ready", 64'({reg_valid_o, ext_ready_o}), 64'(0));
        check("rst_status", 64'({init_done_o, mem_gate_o, init_error_o}), 64'(3'b010));
        check("rst_data", 64'({reg_addr_o, reg_wdata_o} != 0 || reg_wstrb_o != 0 || reg_write_o
                               || ext_rdata_o != 0 || ext_error_o), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        int got = -1;
        for (int k = 0; k < 300 && got < 0; k++) begin
            @(negedge clk);
            #3;
            if (init_done_o) got = cyc;
        end
        check(name, 64'(got), 64'(exp_cyc));
    endtask

    task automatic wait_cyc(input int c);
        int k = 0;
        while (cyc != c && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (cyc != c) check("wait_cycle", 64'(cyc), 64'(c));
    endtask

    task automatic wait_ext(output int hs_cyc);
        hs_cyc = -1;
        for (int k = 0; k < 200 && hs_cyc < 0; k++) begin
            @(negedge clk);
            #3;
            if (ext_valid_i && ext_ready_o) hs_cyc = cyc;
        end
        @(posedge clk);
        #1;
        ext_valid_i = 1'b0;
        ext_write_i = 1'b0;
        ext_addr_i  = '0;
        ext_wdata_i = 32'h0;
        ext_wstrb_i = 4'h0;
    endtask

    initial begin
        int t, hs, base;
        rst = 1'b1;
        reinit = 1'b0;
        ext_valid_i = 1'b0; ext_write_i = 1'b0; ext_addr_i = '0;
        ext_wdata_i = 32'h0; ext_wstrb_i = 4'h0;
        cfg_addr[0] = 48'hA000_0000_0010;
        cfg_addr[1] = 48'hB000_0000_0024;
        cfg_addr[2] = 48'hC000_0000_0038;
        cfg_data[0] = 32'hC0DE_0001;
        cfg_data[1] = 32'hC0DE_0002;
        cfg_data[2] = 32'hC0DE_0003;
        delay_addr = '1; err_addr = '1; delay_n = 0;

        // all entries enabled, immediate ready
        cfg_en = 3'b111;
        base = cfg_hs;
        do_reset();
        push_cfg(0, 8); push_cfg(1, 10); push_cfg(2, 12);
        wait_done("s1_done_cycle", 13);
        check("s1_no_error", 64'(init_error_o), 64'(0));
        check("s1_writes", 64'(cfg_hs - base), 64'(3));

        // only entry 1 enabled
        cfg_en = 3'b010;
        base = cfg_hs;
        do_reset();
        push_cfg(1, 9);
        wait_done("s2a_done_cycle", 11);
        check("s2a_writes", 64'(cfg_hs - base), 64'(1));

        // nothing enabled
        cfg_en = 3'b000;
        base = cfg_hs;
        do_reset();
        wait_done("s2b_done_cycle", 10);
        check("s2b_writes", 64'(cfg_hs - base), 64'(0));

        // error on write 2 with a 5-cycle stall
        cfg_en = 3'b111;
        delay_addr = cfg_addr[1]; delay_n = 5; err_addr = cfg_addr[1];
        do_reset();
        push_cfg(0, 8); push_cfg(1, 15); push_cfg(2, 17);
        wait_cyc(12);
        check("s3_error_before", 64'(init_error_o), 64'(0));
        wait_done("s3_done_cycle", 18);
        check("s3_error_set", 64'(init_error_o), 64'(1));
        repeat (4) @(posedge clk);
        #1;
        check("s3_error_sticky", 64'({init_error_o, init_done_o}), 64'(2'b11));

        // reinit while a stalled SoC write is in flight
        delay_addr = 48'h0000_0000_9ABC; delay_n = 3; err_addr = 48'h0000_0000_9ABC;
        @(posedge clk);
        #1;
        t = cyc;
        ext_valid_i = 1'b1; ext_write_i = 1'b1; ext_addr_i = 48'h0000_0000_9ABC;
        ext_wdata_i = 32'h1357_9BDF; ext_wstrb_i = 4'h6;
        reinit = 1'b1;
        push_ext(32'hA5A5_9ABC, 1'b1);
        push_cfg(0, t + 6); push_cfg(1, t + 8); push_cfg(2, t + 10);
        @(posedge clk);
        #1;
        reinit = 1'b0;
        wait_ext(hs);
        check("s5_ext_hs_cycle", 64'(hs), 64'(t + 3));
        @(negedge clk);
        #3;
        check("s5_hold_done", 64'({init_done_o, mem_gate_o}), 64'(2'b10));
        @(negedge clk);
        #3;
        check("s5_replay_status", 64'({init_done_o, mem_gate_o, init_error_o}), 64'(3'b010));
        wait_done("s5_done_cycle", t + 11);
        check("s5_error_cleared", 64'(init_error_o), 64'(0));

        // SoC request held from cycle 2; reinit outside DONE is ignored
        delay_addr = '1; err_addr = '1; delay_n = 0;
        cfg_en = 3'b111;
        do_reset();
        push_cfg(0, 8); push_cfg(1, 10); push_cfg(2, 12);
        wait_cyc(2);
        ext_valid_i = 1'b1; ext_write_i = 1'b0; ext_addr_i = 48'h0000_0000_5678;
        push_ext(32'hA5A5_5678, 1'b0);
        @(posedge clk);
        #1;
        reinit = 1'b1;
        @(posedge clk);
        #1;
        reinit = 1'b0;
        wait_ext(hs);
        check("s4_ext_hs_cycle", 64'(hs), 64'(13));
        repeat (5) @(posedge clk);
        #1;
        check("s4_still_done", 64'({init_done_o, mem_gate_o}), 64'(2'b10));

        // reset pulsed while write 0 is stalled
        delay_addr = cfg_addr[0]; delay_n = 20;
        base = cfg_hs;
        do_reset();
        push_cfg(0, -1);
        wait_cyc(11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("s6_rst_outputs", 64'({reg_valid_o, init_done_o, mem_gate_o}), 64'(3'b001));
        check("s6_rst_addr", 64'(reg_addr_o), 64'(0));
        exp_q.delete();
        delay_addr = '1;
        push_cfg(0, 8); push_cfg(1, 10); push_cfg(2, 12);
        rst = 1'b0;
        wait_done("s6_done_cycle", 13);
        check("s6_writes", 64'(cfg_hs - base), 64'(3));

        check("cfg_queue_drained", 64'(exp_q.size()), 64'(0));
        check("ext_queue_drained", 64'(ext_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
